mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 47 ++++
 rtl/mem_access_unit_lane.sv | 55 +++++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg -- shared definitions for the data-memory access unit.
// Holds the datapath width macro `LENGTH, the request size encodings, the
// FSM state encoding, the byte-enable constants, the latched-op struct and
// the alignment helper used when MEM_ALIGN_CHECK_EN is defined.
`ifndef LENGTH
`define LENGTH 32
`endif

package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is also treated as word

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } mau_state_t;

  typedef struct packed {
    logic                 write;
    logic [1:0]           size;
    logic                 sgn;
    logic [`LENGTH-1:0]   addr;
    logic [`LENGTH-1:0]   wdata;
  } mem_op_t;

  // Natural alignment: bytes always fit, halves need addr[0]=0,
  // words need addr[1:0]=00.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// mem_lane_align -- combinational lane steering for a 32-bit data port.
// Ports:
//   i_size, i_signed, i_addr_lo : latched access size, sign flag, addr[1:0]
//   i_wdata  : right-aligned store data
//   i_rdata  : raw word from memory
//   o_be     : byte enables for the store/load
//   o_wdata  : store data replicated across all lanes of its size
//   o_rdata  : selected lane, sign- or zero-extended to 32 bits
`ifndef LENGTH
`define LENGTH 32
`endif

module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]         i_size,
  input  logic               i_signed,
  input  logic [1:0]         i_addr_lo,
  input  logic [`LENGTH-1:0] i_wdata,
  input  logic [`LENGTH-1:0] i_rdata,
  output logic [3:0]         o_be,
  output logic [`LENGTH-1:0] o_wdata,
  output logic [`LENGTH-1:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte  = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_be    = BE_WORD;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_be    = BE_BYTE << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        // addr[0] is ignored here; misalignment is caught upstream if enabled
        o_be    = i_addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_signed & w_half[15]}}, w_half};
      end
      default: begin
        o_be    = BE_WORD;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit -- MEM-stage data-memory access FSM (IDLE/REQ/WAIT_R/DONE).
// Latches the EX/MEM op, issues one request on the dmem port, waits for
// read data if needed, and returns the extended load result in a register.
// Ports:
//   clk, rst                : clock (rising edge), async active-low reset
//   req_*                   : memory op from EX/MEM
//   stall                   : freezes PC/IF/ID/EX/MEM while the access is open
//   dmem_*                  : data-memory request/response port
//   Read_memory_data        : registered extended load result
//   mem_done, misalign      : one-cycle completion pulse and alignment fault
// Build option: define MEM_ALIGN_CHECK_EN to turn misaligned half/word
// accesses into an immediate DONE with misalign=1 and no memory request.
`ifndef LENGTH
`define LENGTH 32
`endif

module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic               req_write,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [`LENGTH-1:0] req_addr,
  input  logic [`LENGTH-1:0] req_wdata,
  output logic               stall,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [`LENGTH-1:0] dmem_addr,
  output logic [`LENGTH-1:0] dmem_wdata,
  output logic [3:0]         dmem_be,
  input  logic               dmem_ready,
  input  logic               dmem_rvalid,
  input  logic [`LENGTH-1:0] dmem_rdata,
  output logic [`LENGTH-1:0] Read_memory_data,
  output logic               mem_done,
  output logic               misalign
);

  mau_state_t         r_state;
  mem_op_t            r_op;
  logic               r_req, r_we, r_done, r_misalign;
  logic [`LENGTH-1:0] r_rdata;

  logic [3:0]         w_be;
  logic [`LENGTH-1:0] w_wdata;
  logic [`LENGTH-1:0] w_rdata_ext;
  logic               w_misalign;

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = is_misaligned(req_size, req_addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  // Steering works from the latched op so dmem_* stay stable while held.
  mem_lane_align u_lane (
    .i_size    (r_op.size),
    .i_signed  (r_op.sgn),
    .i_addr_lo (r_op.addr[1:0]),
    .i_wdata   (r_op.wdata),
    .i_rdata   (dmem_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_rdata_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_misalign <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op <= '{write: req_write, size: req_size, sgn: req_signed,
                      addr: req_addr, wdata: req_wdata};
            if (w_misalign) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_misalign <= 1'b1;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_we    <= req_write;
            end
          end
        end
        S_REQ: begin
          if (dmem_ready) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            if (r_op.write || dmem_rvalid) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              if (!r_op.write) r_rdata <= w_rdata_ext;
            end else begin
              r_state <= S_WAIT_R;
            end
          end
        end
        S_WAIT_R: begin
          if (dmem_rvalid) begin
            r_rdata <= w_rdata_ext;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_done     <= 1'b0;
          r_misalign <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // stall must rise in the same cycle a request appears, so it decodes req_valid.
  assign stall = (r_state == S_IDLE && req_valid) ||
                 (r_state == S_REQ) || (r_state == S_WAIT_R);

  assign dmem_req         = r_req;
  assign dmem_we          = r_we;
  assign dmem_addr        = {r_op.addr[`LENGTH-1:2], 2'b00};
  assign dmem_wdata       = w_wdata;
  assign dmem_be          = r_req ? w_be : BE_NONE;
  assign Read_memory_data = r_rdata;
  assign mem_done         = r_done;
  assign misalign         = r_misalign;

endmodule
